config_uart_rx: RTL and testbench
=================================

# config_uart_rx

Upstream feeder for the WSPR transmitter top level. It receives 8N1 UART bytes on a single pin and turns them into the configuration stream the transmitter consumes: `io_config_start`, one-cycle `io_config_valid_in` byte strobes and `io_rf_start`. Configuration is sent as a length-framed packet: STX (0x02), then exactly 21 payload bytes, then optionally ETX (0x03) to key the transmitter. The 21 payload bytes are: 6 callsign chars, 4 locator chars, 1 power, 4+4+2 frequency/tuning bytes.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Must be ≥ 8.
- `PULSE_LEN`, default 10: cycles that `io_config_start` / `io_rf_start` stay high. Must be < 9*`CLKS_PER_BIT`.
- `FRAME_BYTES`, default 21: payload bytes per packet.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `io_rx` in 1: UART line, idle high, asynchronous to `clock`.
- `io_config_bits_in` out 8: payload byte. Holds its value until the next payload byte.
- `io_config_valid_in` out 1: one-cycle strobe per forwarded payload byte.
- `io_config_start` out 1: high for `PULSE_LEN` cycles after STX.
- `io_rf_start` out 1: high for `PULSE_LEN` cycles after an accepted ETX.
- `io_frame_done` out 1: high once all `FRAME_BYTES` bytes have loaded. Cleared by the next STX.
- `io_frame_err` out 1: sticky error flag. Cleared by STX.

## Operation
- Every output resets to 0. All registers clear asynchronously.
- **Input path:** `io_rx` passes through a 2-flop synchronizer. It is reset to 1, so the line reads as idle.
- **Bit receiver FSM** (states RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - RX_IDLE: a synchronized 1→0 transition enters RX_START.
  - RX_START: samples after `CLKS_PER_BIT/2` (integer divide) cycles. If the sample is 1, it is a false start: return to RX_IDLE, emit nothing, no error.
  - RX_DATA: 8 samples spaced `CLKS_PER_BIT` apart, LSB first, shifted into an 8-bit register.
  - RX_STOP: one sample `CLKS_PER_BIT` later.
    - Stop = 1: internal `byte_ok` pulse.
    - Stop = 0: framing error; the byte is dropped and `io_frame_err` is set.
  - After the stop sample, always return to RX_IDLE. There is no wait for the end of the stop bit.
  - In RX_IDLE, a line held low does not re-trigger; a new 1→0 transition is required.
- **Packet FSM** (states P_WAIT, P_START, P_LOAD, P_DONE):
  - P_WAIT: `byte_ok` with 0x02 → P_START. Any other byte is discarded.
  - P_START:
    - Entry clears `io_frame_done`, `io_frame_err` and the byte counter.
    - `io_config_start` stays high for exactly `PULSE_LEN` cycles, then → P_LOAD.
    - A `byte_ok` during P_START is dropped and sets `io_frame_err`.
  - P_LOAD: each `byte_ok` is forwarded regardless of value, so 0x02 and 0x03 are data here.
    - `io_config_bits_in` is updated and `io_config_valid_in` pulses.
    - The counter (5 bits) increments.
    - On the `FRAME_BYTES`-th byte → P_DONE and `io_frame_done` = 1.
  - P_DONE:
    - 0x02 → P_START (new packet).
    - 0x03 → `io_rf_start` high for `PULSE_LEN` cycles; stay in P_DONE.
    - 0x03 while `io_rf_start` is already high is ignored; the pulse is not extended.
    - Other bytes are ignored.
- ETX in P_WAIT or P_LOAD: no `io_rf_start` in either state. In P_LOAD it is treated as data.
- No timeout. A partial packet waits indefinitely; a fresh packet requires reset.

## Timing
- Synchronizer latency: 2 cycles.
- Stop-bit sample cycle = start edge at the synchronizer output + `CLKS_PER_BIT/2` + 9*`CLKS_PER_BIT` cycles.
- `byte_ok` is registered 1 cycle after the stop sample.
- `io_config_valid_in` and `io_config_bits_in` update on the cycle after `byte_ok`. End-to-end latency is fixed and must be identical for every byte.
- `io_config_start` and `io_rf_start` rise on the cycle after the triggering `byte_ok`. Each stays high for exactly `PULSE_LEN` consecutive cycles.
- Minimum spacing between `io_config_valid_in` strobes is about 9.5*`CLKS_PER_BIT` cycles. This satisfies the downstream requirement of a one-cycle strobe followed by at least one idle cycle.
- Reset mid-byte or mid-pulse: all outputs drop to 0 immediately. The receiver returns to RX_IDLE and needs a new falling edge.

## Test plan
- **Single byte:** STX then 0x4B with default parameters.
  - → `io_config_start` high for 10 cycles.
  - → one `io_config_valid_in` strobe with bits = 0x4B.
  - → `io_frame_done` = 0.
- **Full packet:** STX, `" K3RTL"`, `"F0N0"`, 13, 00 01 86 A0, 64 01 A3 6E, 53 E3, then ETX.
  - → exactly 21 strobes, in order, with matching bytes.
  - → `io_frame_done` rises on the 21st strobe.
  - → `io_rf_start` high for 10 cycles after ETX.
- **Control values as payload:** a packet whose payload contains 0x02 and 0x03.
  - → both forwarded as data.
  - → no new `io_config_start`, no `io_rf_start` before `io_frame_done`.
- **Glitch:** 20-cycle low pulse on `io_rx`.
  - → no strobe, `io_frame_err` = 0.
- **Framing error:** mid-packet byte with stop bit = 0.
  - → byte dropped, counter unchanged, `io_frame_err` = 1.
  - → next STX clears `io_frame_err`.
- **Reset mid-byte:** assert `reset` during data bit 4.
  - → all outputs 0 immediately.
  - → after release, a new STX is accepted normally; the partial byte is never emitted.

Source files
------------

// File: rtl/config_uart_rx.sv
// config_uart_rx: 8N1 UART receiver feeding the WSPR transmitter configuration stream.
// A packet is STX (0x02), FRAME_BYTES payload bytes, then an optional ETX (0x03) that keys RF.
//
// Ports:
//   clock               in   sole clock, rising edge
//   reset               in   asynchronous, active-high
//   io_rx               in   UART line, idle high, asynchronous to clock
//   io_config_bits_in   out  last forwarded payload byte (held)
//   io_config_valid_in  out  one-cycle strobe per forwarded payload byte
//   io_config_start     out  PULSE_LEN-cycle pulse after STX
//   io_rf_start         out  PULSE_LEN-cycle pulse after an accepted ETX
//   io_frame_done       out  all payload bytes loaded; cleared by STX
//   io_frame_err        out  sticky error flag; cleared by STX
module config_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned PULSE_LEN    = 10,
  parameter int unsigned FRAME_BYTES  = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rx,
  output logic [7:0] io_config_bits_in,
  output logic       io_config_valid_in,
  output logic       io_config_start,
  output logic       io_rf_start,
  output logic       io_frame_done,
  output logic       io_frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PulW = $clog2(PULSE_LEN + 1);

  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PulW-1:0] PulLast  = PulW'(PULSE_LEN - 1);
  localparam logic [4:0]      FrmLast  = 5'(FRAME_BYTES - 1);

  localparam logic [7:0] Stx = 8'h02;
  localparam logic [7:0] Etx = 8'h03;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {PWait, PStart, PLoad, PDone} pk_state_e;

  // ---------------------------------------------------------------------------
  // Bit receiver
  // ---------------------------------------------------------------------------
  rx_state_e       rx_state;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CntW-1:0] clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      rx_byte;
  logic            byte_ok;
  logic            byte_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Synchronizer resets to 1 so the line reads as idle.
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RxIdle;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
    end else begin
      rx_meta  <= io_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
      unique case (rx_state)
        RxIdle: begin
          // Only a 1->0 transition starts a byte; a line held low does not re-trigger.
          if (rx_prev && !rx_sync) begin
            rx_state <= RxStart;
            clk_cnt  <= '0;
          end
        end
        RxStart: begin
          if (clk_cnt == HalfLast) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // A high mid-start sample is a glitch: drop silently.
            rx_state <= rx_sync ? RxIdle : RxData;
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
        RxData: begin
          if (clk_cnt == BitLast) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              rx_state <= RxStop;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
        RxStop: begin
          if (clk_cnt == BitLast) begin
            clk_cnt  <= '0;
            rx_state <= RxIdle;
            if (rx_sync) begin
              byte_ok <= 1'b1;
              rx_byte <= shift;
            end else begin
              byte_bad <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Packet framer
  // ---------------------------------------------------------------------------
  pk_state_e       pk_state;
  logic [PulW-1:0] cfg_cnt;
  logic [PulW-1:0] rf_cnt;
  logic [4:0]      byte_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pk_state           <= PWait;
      cfg_cnt            <= '0;
      rf_cnt             <= '0;
      byte_cnt           <= '0;
      io_config_bits_in  <= '0;
      io_config_valid_in <= 1'b0;
      io_config_start    <= 1'b0;
      io_rf_start        <= 1'b0;
      io_frame_done      <= 1'b0;
      io_frame_err       <= 1'b0;
    end else begin
      io_config_valid_in <= 1'b0;

      // The RF pulse runs on its own counter so a new STX cannot truncate it.
      if (io_rf_start) begin
        if (rf_cnt == PulLast) begin
          io_rf_start <= 1'b0;
        end else begin
          rf_cnt <= rf_cnt + PulW'(1);
        end
      end

      if (byte_bad) begin
        io_frame_err <= 1'b1;
      end

      unique case (pk_state)
        PWait: begin
          if (byte_ok && rx_byte == Stx) begin
            pk_state        <= PStart;
            io_config_start <= 1'b1;
            cfg_cnt         <= '0;
            byte_cnt        <= '0;
            io_frame_done   <= 1'b0;
            io_frame_err    <= 1'b0;
          end
        end
        PStart: begin
          if (cfg_cnt == PulLast) begin
            io_config_start <= 1'b0;
            pk_state        <= PLoad;
          end else begin
            cfg_cnt <= cfg_cnt + PulW'(1);
          end
          if (byte_ok) begin
            io_frame_err <= 1'b1;
          end
        end
        PLoad: begin
          // Every byte is payload here, including 0x02 and 0x03.
          if (byte_ok) begin
            io_config_bits_in  <= rx_byte;
            io_config_valid_in <= 1'b1;
            byte_cnt           <= byte_cnt + 5'd1;
            if (byte_cnt == FrmLast) begin
              pk_state      <= PDone;
              io_frame_done <= 1'b1;
            end
          end
        end
        PDone: begin
          if (byte_ok) begin
            if (rx_byte == Stx) begin
              pk_state        <= PStart;
              io_config_start <= 1'b1;
              cfg_cnt         <= '0;
              byte_cnt        <= '0;
              io_frame_done   <= 1'b0;
              io_frame_err    <= 1'b0;
            end else if (rx_byte == Etx && !io_rf_start) begin
              io_rf_start <= 1'b1;
              rf_cnt      <= '0;
            end
          end
        end
        default: pk_state <= PWait;
      endcase
    end
  end

endmodule

// File: tb/tb_config_uart_rx.sv
// Directed bench for config_uart_rx with default parameters.
module tb_config_uart_rx;

  localparam int unsigned Cpb = 104;

  logic       clock;
  logic       reset;
  logic       io_rx;
  logic [7:0] io_config_bits_in;
  logic       io_config_valid_in;
  logic       io_config_start;
  logic       io_rf_start;
  logic       io_frame_done;
  logic       io_frame_err;

  config_uart_rx dut (
    .clock              (clock),
    .reset              (reset),
    .io_rx              (io_rx),
    .io_config_bits_in  (io_config_bits_in),
    .io_config_valid_in (io_config_valid_in),
    .io_config_start    (io_config_start),
    .io_rf_start        (io_rf_start),
    .io_frame_done      (io_frame_done),
    .io_frame_err       (io_frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Output monitor: collects strobes and measures pulse widths.
  logic [7:0] strobe_q[$];
  logic       done_q[$];
  int cs_run = 0, cs_width = 0, cs_pulses = 0;
  int rf_run = 0, rf_width = 0, rf_pulses = 0;
  int rf_early = 0;

  always @(negedge clock) begin
    if (io_config_valid_in) begin
      strobe_q.push_back(io_config_bits_in);
      done_q.push_back(io_frame_done);
    end
    if (io_rf_start && !io_frame_done) rf_early++;
    if (io_config_start) cs_run++;
    else if (cs_run != 0) begin
      cs_width = cs_run;
      cs_pulses++;
      cs_run = 0;
    end
    if (io_rf_start) rf_run++;
    else if (rf_run != 0) begin
      rf_width = rf_run;
      rf_pulses++;
      rf_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bit();
    repeat (Cpb) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    io_rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      wait_bit();
    end
    io_rx = stop;
    wait_bit();
    io_rx = 1'b1;
    repeat (Cpb / 2) @(negedge clock);
  endtask

  task automatic clear_mon();
    strobe_q.delete();
    done_q.delete();
    cs_pulses = 0;
    cs_width  = 0;
    rf_pulses = 0;
    rf_width  = 0;
    rf_early  = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  logic [7:0] pkt[21];
  logic [7:0] ctl[21];

  initial begin
    pkt = '{8'h20, 8'h4B, 8'h33, 8'h52, 8'h54, 8'h4C,
            8'h46, 8'h30, 8'h4E, 8'h30,
            8'h13,
            8'h00, 8'h01, 8'h86, 8'hA0,
            8'h64, 8'h01, 8'hA3, 8'h6E,
            8'h53, 8'hE3};
    for (int k = 0; k < 21; k++) ctl[k] = 8'h40 + 8'(k);
    ctl[2]  = 8'h02;
    ctl[9]  = 8'h03;
    ctl[20] = 8'h03;

    reset = 1'b1;
    io_rx = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_bits",  {24'd0, io_config_bits_in}, 32'h00);
    check("rst_valid", {31'd0, io_config_valid_in}, 32'd0);
    check("rst_cfg",   {31'd0, io_config_start}, 32'd0);
    check("rst_rf",    {31'd0, io_rf_start}, 32'd0);
    check("rst_done",  {31'd0, io_frame_done}, 32'd0);
    check("rst_err",   {31'd0, io_frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Glitch: 20-cycle low pulse is a false start.
    io_rx = 1'b0;
    repeat (20) @(negedge clock);
    io_rx = 1'b1;
    repeat (2 * Cpb) @(negedge clock);
    check("glitch_strobes", strobe_q.size(), 0);
    check("glitch_err", {31'd0, io_frame_err}, 32'd0);

    // Single byte after STX.
    send_byte(8'h02, 1'b1);
    check("single_cfg_pulses", cs_pulses, 1);
    check("single_cfg_width", cs_width, 10);
    send_byte(8'h4B, 1'b1);
    check("single_strobes", strobe_q.size(), 1);
    check("single_byte", {24'd0, strobe_q[0]}, 32'h4B);
    check("single_bits_hold", {24'd0, io_config_bits_in}, 32'h4B);
    check("single_done", {31'd0, io_frame_done}, 32'd0);

    // Full packet then ETX.
    pulse_reset();
    clear_mon();
    send_byte(8'h02, 1'b1);
    for (int k = 0; k < 21; k++) send_byte(pkt[k], 1'b1);
    check("full_strobes", strobe_q.size(), 21);
    for (int k = 0; k < 21; k++) check($sformatf("full_byte%0d", k), {24'd0, strobe_q[k]},
                                       {24'd0, pkt[k]});
    check("full_done_at20", {31'd0, done_q[19]}, 32'd0);
    check("full_done_at21", {31'd0, done_q[20]}, 32'd1);
    check("full_done", {31'd0, io_frame_done}, 32'd1);
    check("full_rf_none", rf_pulses, 0);
    send_byte(8'h03, 1'b1);
    check("etx_rf_pulses", rf_pulses, 1);
    check("etx_rf_width", rf_width, 10);

    // New packet from P_DONE carrying 0x02/0x03 as data, with a framing error mid-packet.
    clear_mon();
    send_byte(8'h02, 1'b1);
    check("ctl_done_cleared", {31'd0, io_frame_done}, 32'd0);
    for (int k = 0; k < 5; k++) send_byte(ctl[k], 1'b1);
    send_byte(8'hAA, 1'b0);
    check("ferr_flag", {31'd0, io_frame_err}, 32'd1);
    check("ferr_dropped", strobe_q.size(), 5);
    for (int k = 5; k < 21; k++) send_byte(ctl[k], 1'b1);
    check("ctl_strobes", strobe_q.size(), 21);
    check("ctl_byte2", {24'd0, strobe_q[2]}, 32'h02);
    check("ctl_byte9", {24'd0, strobe_q[9]}, 32'h03);
    check("ctl_byte20", {24'd0, strobe_q[20]}, 32'h03);
    check("ctl_byte15", {24'd0, strobe_q[15]}, 32'h4F);
    check("ctl_cfg_pulses", cs_pulses, 1);
    check("ctl_rf_pulses", rf_pulses, 0);
    check("ctl_rf_early", rf_early, 0);
    check("ctl_done", {31'd0, io_frame_done}, 32'd1);
    check("ctl_err_sticky", {31'd0, io_frame_err}, 32'd1);

    send_byte(8'h02, 1'b1);
    check("stx_clears_err", {31'd0, io_frame_err}, 32'd0);
    check("stx_clears_done", {31'd0, io_frame_done}, 32'd0);
    check("stx_cfg_pulses", cs_pulses, 2);
    send_byte(8'h77, 1'b1);
    check("pre_rst_bits", {24'd0, io_config_bits_in}, 32'h77);

    // Reset during data bit 4 of a byte.
    io_rx = 1'b0;
    repeat (5) wait_bit();
    repeat (Cpb / 2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_bits", {24'd0, io_config_bits_in}, 32'h00);
    check("midrst_valid", {31'd0, io_config_valid_in}, 32'd0);
    check("midrst_cfg", {31'd0, io_config_start}, 32'd0);
    check("midrst_rf", {31'd0, io_rf_start}, 32'd0);
    check("midrst_done", {31'd0, io_frame_done}, 32'd0);
    check("midrst_err", {31'd0, io_frame_err}, 32'd0);
    io_rx = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    clear_mon();
    send_byte(8'h02, 1'b1);
    check("post_rst_cfg_pulses", cs_pulses, 1);
    check("post_rst_cfg_width", cs_width, 10);
    check("post_rst_no_partial", strobe_q.size(), 0);
    send_byte(8'h5A, 1'b1);
    check("post_rst_strobes", strobe_q.size(), 1);
    check("post_rst_byte", {24'd0, strobe_q[0]}, 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
